// File: rtl/fifo_pkg.sv
// Shared FIFO constants: default widths, depth derivation and pointer width.
package fifo_pkg;

    localparam int DEF_ADDR_SIZE = 3;
    localparam int DEF_DATA_SIZE = 8;
    localparam int DEF_DEPTH     = 1 << DEF_ADDR_SIZE;
    localparam int DEF_PTR_W     = DEF_ADDR_SIZE + 1;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int fifo_ptr_w(input int addr_size);
        return addr_size + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_reg.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
// Only the read output register is reset; the array itself is not.
module fifo_ram_reg
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [DATA_SIZE-1:0] wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [DATA_SIZE-1:0] rdata_o
);

    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, full/empty and almost flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is defined.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE     = DEF_ADDR_SIZE,
    parameter int DATA_SIZE     = DEF_DATA_SIZE,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
`ifdef SYNC_FIFO_ERR_EN
    input  logic                 err_clr,
    output logic                 overflow,
    output logic                 underflow,
`endif
    input  logic                 wr_en,
    input  logic [DATA_SIZE-1:0] wdata,
    input  logic                 rd_en,
    output logic [DATA_SIZE-1:0] rdata,
    output logic                 rvalid,
    output logic                 wfull,
    output logic                 rempty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_SIZE:0]   count
);

    localparam int PTR_W = fifo_ptr_w(ADDR_SIZE);
    localparam logic [PTR_W-1:0] AFULL_C  = PTR_W'(AFULL_THRESH);
    localparam logic [PTR_W-1:0] AEMPTY_C = PTR_W'(AEMPTY_THRESH);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W-1:0] count_q, count_d;
    logic             rvalid_q, rvalid_d;
    logic             wr_accept, rd_accept;

    // Handshake: wr_en/rd_en are requests, accepted at a rising edge only while
    // !wfull / !rempty; rvalid is high the cycle after an accepted read and marks
    // the popped word on rdata. Rejected requests change no state.
    assign rempty    = (wptr_q == rptr_q);
    assign wfull     = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                       (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
    assign wr_accept = wr_en && !wfull;
    assign rd_accept = rd_en && !rempty;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rvalid_d = rd_accept;
        if (wr_accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_accept) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
        end
    end

    fifo_ram_reg #(
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE)
    ) u_ram (
        .clk_i   (wclk),
        .rst_ni  (wrst_n),
        .we_i    (wr_accept),
        .waddr_i (wptr_q[PTR_W-2:0]),
        .wdata_i (wdata),
        .re_i    (rd_accept),
        .raddr_i (rptr_q[PTR_W-2:0]),
        .rdata_o (rdata)
    );

    assign rvalid       = rvalid_q;
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_C);
    assign almost_empty = (count_q <= AEMPTY_C);

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // A set condition in the same cycle as err_clr wins.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (wr_en && wfull) begin
            overflow_d = 1'b1;
        end else if (err_clr) begin
            overflow_d = 1'b0;
        end
        if (rd_en && rempty) begin
            underflow_d = 1'b1;
        end else if (err_clr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    // Without error flags, rejected requests are silently dropped.
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo against a queue-based reference model.
// Builds the error-flag checks when SYNC_FIFO_ERR_EN is defined.
module tb_sync_fifo;
    import fifo_pkg::*;

    localparam int DW     = DEF_DATA_SIZE;
    localparam int DEPTH  = DEF_DEPTH;
    localparam int AF_TH  = 6;
    localparam int AE_TH  = 1;

    logic                 wclk = 1'b0;
    logic                 wrst_n;
    logic                 wr_en;
    logic                 rd_en;
    logic                 err_clr;
    logic [DW-1:0]        wdata;
    logic [DW-1:0]        rdata;
    logic                 rvalid;
    logic                 wfull;
    logic                 rempty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [DEF_PTR_W-1:0] count;
`ifdef SYNC_FIFO_ERR_EN
    logic                 overflow;
    logic                 underflow;
`endif

    // Reference model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_rdata;
    logic          exp_rvalid;
    logic          exp_ovf;
    logic          exp_unf;
    int            checks;
    int            failures;

    always #5 wclk = ~wclk;

    sync_fifo #(
        .ADDR_SIZE     (DEF_ADDR_SIZE),
        .DATA_SIZE     (DW),
        .AFULL_THRESH  (AF_TH),
        .AEMPTY_THRESH (AE_TH)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
`ifdef SYNC_FIFO_ERR_EN
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow),
`endif
        .wr_en        (wr_en),
        .wdata        (wdata),
        .rd_en        (rd_en),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .wfull        (wfull),
        .rempty       (rempty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = exp_q.size();
        check("count", 32'(count), 32'(n));
        check("rempty", 32'(rempty), 32'(n == 0));
        check("wfull", 32'(wfull), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'(n >= AF_TH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AE_TH));
        check("rvalid", 32'(rvalid), 32'(exp_rvalid));
        check("rdata", 32'(rdata), 32'(exp_rdata));
`ifdef SYNC_FIFO_ERR_EN
        check("overflow", 32'(overflow), 32'(exp_ovf));
        check("underflow", 32'(underflow), 32'(exp_unf));
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic cycle(input logic we, input logic [DW-1:0] wd, input logic re,
                         input logic rst, input logic clr);
        int n;
        wr_en   = we;
        wdata   = wd;
        rd_en   = re;
        wrst_n  = !rst;
        err_clr = clr;
        @(posedge wclk);
        n = exp_q.size();
        if (rst) begin
            exp_q.delete();
            exp_rvalid = 1'b0;
            exp_rdata  = '0;
            exp_ovf    = 1'b0;
            exp_unf    = 1'b0;
        end else begin
            exp_rvalid = re && (n > 0);
            if (we && n == DEPTH) exp_ovf = 1'b1;
            else if (clr)         exp_ovf = 1'b0;
            if (re && n == 0)     exp_unf = 1'b1;
            else if (clr)         exp_unf = 1'b0;
            if (exp_rvalid) exp_rdata = exp_q.pop_front();
            if (we && n < DEPTH) exp_q.push_back(wd);
        end
        #1;
        check_all();
    endtask

    function automatic logic [DW-1:0] rnd_byte();
        return DW'($urandom_range(0, (1 << DW) - 1));
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
        exp_ovf    = 1'b0;
        exp_unf    = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        wdata      = '0;
        wrst_n     = 1'b0;
        err_clr    = 1'b0;

        // Reset for two cycles, then idle
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 1, 0);
        cycle(0, '0, 0, 0, 0);

        // Fill with 0x10..0x17, then a rejected write of 0xFF
        for (int i = 0; i < DEPTH; i++) cycle(1, DW'(32'h10 + i), 0, 0, 0);
        cycle(1, 8'hFF, 0, 0, 0);

        // Drain eight words, then a read on empty
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, '0, 1, 0, 0);

        // Simultaneous read/write at count 3
        for (int i = 0; i < 3; i++) cycle(1, rnd_byte(), 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, rnd_byte(), 1, 0, 0);
        while (exp_q.size() > 0) cycle(0, '0, 1, 0, 0);

        // Both requests when empty, then when full
        cycle(1, rnd_byte(), 1, 0, 0);
        while (exp_q.size() < DEPTH) cycle(1, rnd_byte(), 0, 0, 0);
        cycle(1, rnd_byte(), 1, 0, 0);
        while (exp_q.size() > 0) cycle(0, '0, 1, 0, 0);

        // Interleaved push/pop to carry both pointers past 2*DEPTH
        for (int i = 0; i < 20; i++) begin
            cycle(1, rnd_byte(), 0, 0, 0);
            cycle(0, '0, 1, 0, 0);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), rnd_byte(), 1'($urandom_range(0, 1)), 0, 0);
        end

        // Reset mid-operation with a read presented at count 5
        while (exp_q.size() > 0) cycle(0, '0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, rnd_byte(), 0, 0, 0);
        cycle(0, '0, 1, 1, 0);
        cycle(0, '0, 0, 0, 0);

`ifdef SYNC_FIFO_ERR_EN
        // Overflow is sticky until err_clr; set wins over a concurrent clear
        while (exp_q.size() < DEPTH) cycle(1, rnd_byte(), 0, 0, 0);
        cycle(1, rnd_byte(), 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, '0, 0, 0, 0);
        cycle(1, rnd_byte(), 0, 0, 1);
        cycle(0, '0, 0, 0, 1);
        while (exp_q.size() > 0) cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 1, 0, 0);
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
